// File: rtl/edge_event_arbiter.sv
// Programmable per-channel edge/pulse detectors feeding a round-robin
// arbiter that hands pending events to one consumer over valid/ready.

// Per-channel detector: history, event detect, pending latch, sticky overflow.
module edge_event_lane (
  input  logic       clk,
  input  logic       rst,
  input  logic       a,
  input  logic [1:0] mode,
  input  logic       grant,
  input  logic       ovf_clr,
  output logic       pending,
  output logic       ovf
);

  logic h1;
  logic h2;
  logic det;

  // Detector decode; mode takes effect in the same cycle it is applied.
  always_comb begin
    det = 1'b0;
    case (mode)
      2'b01:   det = ~h1 & a;
      2'b10:   det = h1 & ~a;
      2'b11:   det = ~h2 & h1 & ~a;
      default: det = 1'b0;
    endcase
  end

  // History shifts every cycle; a grant only releases pending if no new
  // event arrives in the same cycle, and a new event on an ungranted pending
  // channel is merged and flagged. A fresh overflow beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      h1      <= 1'b0;
      h2      <= 1'b0;
      pending <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      h1      <= a;
      h2      <= h1;
      pending <= det | (pending & ~grant);
      ovf     <= (det & pending & ~grant) | (ovf & ~ovf_clr);
    end
  end

endmodule

// Top: N_CH lanes plus an IDLE/OFFER handshake FSM with round-robin pick.
module edge_event_arbiter #(
  parameter int N_CH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_CH-1:0]           a,
  input  logic [2*N_CH-1:0]         mode,
  input  logic                      ev_ready,
  output logic                      ev_valid,
  output logic [$clog2(N_CH)-1:0]   ev_ch,
  output logic [N_CH-1:0]           ovf,
  input  logic [N_CH-1:0]           ovf_clr
);

  localparam int CH_W = $clog2(N_CH);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t            state;
  logic [CH_W-1:0]   rr_ptr;
  logic [N_CH-1:0]   pending;
  logic [N_CH-1:0]   grant_vec;
  logic              grant;
  logic              pick_found;
  logic [CH_W-1:0]   pick_ch;
  logic [CH_W-1:0]   rr_next;

  assign grant = (state == OFFER) & ev_valid & ev_ready;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_lane
      assign grant_vec[gi] = grant & (ev_ch == CH_W'(gi));
      edge_event_lane u_lane (
        .clk     (clk),
        .rst     (rst),
        .a       (a[gi]),
        .mode    (mode[2*gi+1:2*gi]),
        .grant   (grant_vec[gi]),
        .ovf_clr (ovf_clr[gi]),
        .pending (pending[gi]),
        .ovf     (ovf[gi])
      );
    end
  endgenerate

  // First pending channel scanning upward from rr_ptr, wrapping at N_CH.
  always_comb begin
    int idx;
    pick_found = 1'b0;
    pick_ch    = '0;
    idx        = 0;
    for (int k = 0; k < N_CH; k++) begin
      idx = (int'(rr_ptr) + k) % N_CH;
      if (!pick_found && pending[idx]) begin
        pick_found = 1'b1;
        pick_ch    = CH_W'(idx);
      end
    end
  end

  // Pointer moves just past the granted channel so it goes last next round.
  always_comb begin
    rr_next = (ev_ch == CH_W'(N_CH - 1)) ? '0 : ev_ch + CH_W'(1);
  end

  // Handshake FSM: offer is registered and held stable until accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ev_valid <= 1'b0;
      ev_ch    <= '0;
      rr_ptr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            ev_ch    <= pick_ch;
            ev_valid <= 1'b1;
            state    <= OFFER;
          end
        end
        OFFER: begin
          if (ev_ready) begin
            ev_valid <= 1'b0;
            rr_ptr   <= rr_next;
            state    <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          ev_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed vector table plus short hand-written sequences for edge_event_arbiter.
module tb_edge_event_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic [7:0] mode;
  logic       ev_ready;
  logic       ev_valid;
  logic [1:0] ev_ch;
  logic [3:0] ovf;
  logic [3:0] ovf_clr;

  int n_chk;
  int n_pass;

  typedef struct {
    logic       rst;
    logic [3:0] a;
    logic [7:0] mode;
    logic       rdy;
    logic [3:0] clr;
    logic       v;
    logic [1:0] ch;
    logic [3:0] ovf;
  } vec_t;

  vec_t vt[$];

  edge_event_arbiter #(.N_CH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .mode     (mode),
    .ev_ready (ev_ready),
    .ev_valid (ev_valid),
    .ev_ch    (ev_ch),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic r, input logic [3:0] ai, input logic [7:0] m,
                     input logic rd, input logic [3:0] c, input logic v,
                     input logic [1:0] ch, input logic [3:0] o);
    vec_t e;
    e.rst = r; e.a = ai; e.mode = m; e.rdy = rd; e.clr = c;
    e.v = v; e.ch = ch; e.ovf = o;
    vt.push_back(e);
  endtask

  // Drive inputs, take one clock, settle just after the edge.
  task automatic step(input logic r, input logic [3:0] ai, input logic [7:0] m,
                      input logic rd, input logic [3:0] c);
    rst = r; a = ai; mode = m; ev_ready = rd; ovf_clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  initial begin
    int cyc;
    n_chk = 0; n_pass = 0;
    rst = 1'b1; a = '0; mode = '0; ev_ready = 1'b0; ovf_clr = '0;

    // reset state
    add(1, 4'h0, 8'h55, 1, 0, 0, 0, 0);
    add(0, 4'h0, 8'h55, 1, 0, 0, 0, 0);
    // single rise on ch2: pending, then offer 2 cycles after detect, 1 cycle wide
    add(0, 4'h0, 8'h55, 1, 0, 0, 0, 0);
    add(0, 4'h4, 8'h55, 1, 0, 0, 0, 0);
    add(0, 4'h4, 8'h55, 1, 0, 1, 2, 0);
    add(0, 4'h4, 8'h55, 1, 0, 0, 2, 0);
    add(0, 4'h4, 8'h55, 1, 0, 0, 2, 0);
    add(0, 4'h0, 8'h55, 1, 0, 0, 2, 0);
    // pulse mode ch0: 0,1,0 -> event
    add(0, 4'h0, 8'h03, 1, 0, 0, 2, 0);
    add(0, 4'h1, 8'h03, 1, 0, 0, 2, 0);
    add(0, 4'h0, 8'h03, 1, 0, 0, 2, 0);
    add(0, 4'h0, 8'h03, 1, 0, 1, 0, 0);
    add(0, 4'h0, 8'h03, 1, 0, 0, 0, 0);
    // pulse mode ch0: 0,1,1,0 -> nothing
    add(0, 4'h1, 8'h03, 1, 0, 0, 0, 0);
    add(0, 4'h1, 8'h03, 1, 0, 0, 0, 0);
    add(0, 4'h0, 8'h03, 1, 0, 0, 0, 0);
    add(0, 4'h0, 8'h03, 1, 0, 0, 0, 0);
    // fall mode ch0: 0,1,1,0 -> one event
    add(0, 4'h0, 8'h02, 1, 0, 0, 0, 0);
    add(0, 4'h1, 8'h02, 1, 0, 0, 0, 0);
    add(0, 4'h1, 8'h02, 1, 0, 0, 0, 0);
    add(0, 4'h0, 8'h02, 1, 0, 0, 0, 0);
    add(0, 4'h0, 8'h02, 1, 0, 1, 0, 0);
    add(0, 4'h0, 8'h02, 1, 0, 0, 0, 0);
    // all rise together from rr_ptr=0 -> 0,1,2,3
    add(1, 4'h0, 8'h55, 1, 0, 0, 0, 0);
    add(0, 4'h0, 8'h55, 1, 0, 0, 0, 0);
    add(0, 4'hF, 8'h55, 1, 0, 0, 0, 0);
    add(0, 4'hF, 8'h55, 1, 0, 1, 0, 0);
    add(0, 4'hF, 8'h55, 1, 0, 0, 0, 0);
    add(0, 4'hF, 8'h55, 1, 0, 1, 1, 0);
    add(0, 4'hF, 8'h55, 1, 0, 0, 1, 0);
    add(0, 4'hF, 8'h55, 1, 0, 1, 2, 0);
    add(0, 4'hF, 8'h55, 1, 0, 0, 2, 0);
    add(0, 4'hF, 8'h55, 1, 0, 1, 3, 0);
    add(0, 4'hF, 8'h55, 1, 0, 0, 3, 0);
    add(0, 4'hF, 8'h55, 1, 0, 0, 3, 0);
    // grant ch1 alone to move rr_ptr to 2, then all rise -> 2,3,0,1
    add(0, 4'h0, 8'h55, 1, 0, 0, 3, 0);
    add(0, 4'h2, 8'h55, 1, 0, 0, 3, 0);
    add(0, 4'h2, 8'h55, 1, 0, 1, 1, 0);
    add(0, 4'h2, 8'h55, 1, 0, 0, 1, 0);
    add(0, 4'h0, 8'h55, 1, 0, 0, 1, 0);
    add(0, 4'hF, 8'h55, 1, 0, 0, 1, 0);
    add(0, 4'hF, 8'h55, 1, 0, 1, 2, 0);
    add(0, 4'hF, 8'h55, 1, 0, 0, 2, 0);
    add(0, 4'hF, 8'h55, 1, 0, 1, 3, 0);
    add(0, 4'hF, 8'h55, 1, 0, 0, 3, 0);
    add(0, 4'hF, 8'h55, 1, 0, 1, 0, 0);
    add(0, 4'hF, 8'h55, 1, 0, 0, 0, 0);
    add(0, 4'hF, 8'h55, 1, 0, 1, 1, 0);
    add(0, 4'hF, 8'h55, 1, 0, 0, 1, 0);
    // backpressure on ch1 offer, second rise -> ovf[1], then clear
    add(0, 4'h0, 8'h55, 0, 0, 0, 1, 0);
    add(0, 4'h2, 8'h55, 0, 0, 0, 1, 0);
    add(0, 4'h2, 8'h55, 0, 0, 1, 1, 0);
    add(0, 4'h0, 8'h55, 0, 0, 1, 1, 0);
    add(0, 4'h2, 8'h55, 0, 0, 1, 1, 4'h2);
    for (int i = 0; i < 6; i++) add(0, 4'h2, 8'h55, 0, 0, 1, 1, 4'h2);
    add(0, 4'h2, 8'h55, 0, 4'h2, 1, 1, 0);
    add(0, 4'h2, 8'h55, 1, 0, 0, 1, 0);
    add(0, 4'h0, 8'h55, 1, 0, 0, 1, 0);
    // ch3 fall mode: grant coincides with a new fall -> re-offered, no ovf
    add(0, 4'h8, 8'h80, 1, 0, 0, 1, 0);
    add(0, 4'h0, 8'h80, 1, 0, 0, 1, 0);
    add(0, 4'h8, 8'h80, 0, 0, 1, 3, 0);
    add(0, 4'h0, 8'h80, 1, 0, 0, 3, 0);
    add(0, 4'h0, 8'h80, 0, 0, 1, 3, 0);
    add(0, 4'h0, 8'h80, 1, 0, 0, 3, 0);
    // reset mid-handshake with 3 pending and overflow set
    add(0, 4'h0, 8'h55, 0, 0, 0, 3, 0);
    add(0, 4'h7, 8'h55, 0, 0, 0, 3, 0);
    add(0, 4'h7, 8'h55, 0, 0, 1, 0, 0);
    add(0, 4'h0, 8'h55, 0, 0, 1, 0, 0);
    add(0, 4'h7, 8'h55, 0, 0, 1, 0, 4'h7);
    add(1, 4'h7, 8'h55, 0, 0, 0, 0, 0);
    add(0, 4'h0, 8'h55, 1, 0, 0, 0, 0);
    add(0, 4'h0, 8'h55, 1, 0, 0, 0, 0);
    // input high straight out of reset counts as a rise
    add(1, 4'h1, 8'h55, 1, 0, 0, 0, 0);
    add(0, 4'h1, 8'h55, 1, 0, 0, 0, 0);
    add(0, 4'h1, 8'h55, 1, 0, 1, 0, 0);
    add(0, 4'h1, 8'h55, 1, 0, 0, 0, 0);

    foreach (vt[i]) begin
      step(vt[i].rst, vt[i].a, vt[i].mode, vt[i].rdy, vt[i].clr);
      check($sformatf("row%0d ev_valid", i), int'(ev_valid), int'(vt[i].v));
      check($sformatf("row%0d ev_ch", i),    int'(ev_ch),    int'(vt[i].ch));
      check($sformatf("row%0d ovf", i),      int'(ovf),      int'(vt[i].ovf));
    end

    // overflow set and clear in the same cycle: set wins
    step(1, 4'h0, 8'h55, 0, 0);
    step(0, 4'h1, 8'h55, 0, 0);
    step(0, 4'h0, 8'h55, 0, 0);
    check("offer_ch0", int'(ev_valid), 1);
    step(0, 4'h1, 8'h55, 0, 4'h1);
    check("ovf_set_wins", int'(ovf), 1);
    step(0, 4'h1, 8'h55, 0, 4'h1);
    check("ovf_cleared", int'(ovf), 0);
    step(0, 4'h1, 8'h55, 1, 0);
    check("grant_drops_valid", int'(ev_valid), 0);

    // bounded wait for a new offer: latency from detect edge must be 2
    step(0, 4'h0, 8'h55, 1, 0);
    cyc = 0;
    do begin
      step(0, 4'h4, 8'h55, 0, 0);
      cyc++;
    end while (!ev_valid && cyc < 8);
    check("offer_latency", cyc, 2);
    check("offer_latency_ch", int'(ev_ch), 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
